// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp codes, funct values,
// decoded ALU operations, forwarding selects and multiplier FSM states.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT,
    ALU_MULTU, ALU_MFHI, ALU_MFLO, ALU_NOP
  } alu_ctl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

  // Map ALUOp plus funct onto a single ALU operation.
  function automatic alu_ctl_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_ctl_t ctl;
    ctl = ALU_NOP;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_SLT: ctl = ALU_SLT;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD:   ctl = ALU_ADD;
          FUNCT_SUB:   ctl = ALU_SUB;
          FUNCT_AND:   ctl = ALU_AND;
          FUNCT_OR:    ctl = ALU_OR;
          FUNCT_SLT:   ctl = ALU_SLT;
          FUNCT_MULTU: ctl = ALU_MULTU;
          FUNCT_MFHI:  ctl = ALU_MFHI;
          FUNCT_MFLO:  ctl = ALU_MFLO;
          default:     ctl = ALU_NOP;
        endcase
      end
      default: ctl = ALU_NOP;
    endcase
    return ctl;
  endfunction

  // Forwarding mux; the unused code 11 falls back to the register file value.
  function automatic logic [31:0] fwd_select(input logic [1:0] sel, input logic [31:0] rf_val,
                                             input logic [31:0] mem_val, input logic [31:0] wb_val);
    logic [31:0] v;
    case (sel)
      FWD_MEM: v = mem_val;
      FWD_WB:  v = wb_val;
      FWD_REG: v = rf_val;
      default: v = rf_val;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/multu_seq.sv
// Iterative 32-step unsigned shift-add multiplier with HI/LO result registers.
//
// state | meaning
// IDLE  | waiting; a start latches operands and clears accumulator/counter
// BUSY  | one partial product added per cycle, counter 0..31
// DONE  | product committed to HI/LO; one cycle so the pipeline can advance
module multu_seq
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mul_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic [63:0] acc_next;

  // Current partial product (A shifted by the bit position) added to the accumulator.
  always_comb begin
    acc_next = acc;
    if (b_q[cnt]) acc_next = acc + ({32'b0, a_q} << cnt);
  end

  // Multiplier FSM; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi    <= acc_next[63:32];
            lo    <= acc_next[31:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, MULTU sequencer
// and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        ALUSrc_in,
  input  logic [1:0]  ALUOp_in,
  input  logic        RegDst_in,
  input  logic [31:0] RegRsData_in,
  input  logic [31:0] RegRtData_in,
  input  logic [31:0] Immediate_in,
  input  logic [4:0]  instr_Rt_addr_in,
  input  logic [4:0]  instr_Rd_addr_in,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] WB_WriteData,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] MemWriteData_out,
  output logic [4:0]  WriteReg_addr_out,
  output logic        stall_out
);

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  alu_ctl_t    alu_ctl;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] hi;
  logic [31:0] lo;

  assign op_a      = fwd_select(ForwardA, RegRsData_in, MEM_ALUResult, WB_WriteData);
  assign fwd_b     = fwd_select(ForwardB, RegRtData_in, MEM_ALUResult, WB_WriteData);
  assign op_b      = ALUSrc_in ? Immediate_in : fwd_b;
  assign write_reg = RegDst_in ? instr_Rd_addr_in : instr_Rt_addr_in;
  assign alu_ctl   = alu_decode(ALUOp_in, Immediate_in[5:0]);
  assign mul_start = (alu_ctl == ALU_MULTU);

  // The multu is still held in ID/EX during DONE, so it must not stall there.
  assign stall_out = mul_busy | (mul_start & ~mul_done);

  // ALU result selection; multu and unknown functs produce zero.
  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_SLT:  alu_result = {31'b0, ($signed(op_a) < $signed(op_b))};
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  multu_seq u_multu (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (op_a),
    .b     (op_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .hi    (hi),
    .lo    (lo)
  );

  // EX/MEM register; loads a bubble while stalled and in the multiplier DONE cycle.
  always_ff @(posedge clk) begin
    if (rst || stall_out || mul_done) begin
      RegWrite_out      <= 1'b0;
      MemtoReg_out      <= 1'b0;
      MemRead_out       <= 1'b0;
      MemWrite_out      <= 1'b0;
      ALUResult_out     <= '0;
      MemWriteData_out  <= '0;
      WriteReg_addr_out <= '0;
    end else begin
      RegWrite_out      <= RegWrite_in;
      MemtoReg_out      <= MemtoReg_in;
      MemRead_out       <= MemRead_in;
      MemWrite_out      <= MemWrite_in;
      ALUResult_out     <= alu_result;
      MemWriteData_out  <= fwd_b;
      WriteReg_addr_out <= write_reg;
    end
  end

endmodule
